// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: round-robin write-back arbiter for the register file write port with a RAW/WAW pending scoreboard
//   clk_i           rising-edge clock
//   rst_ni          synchronous active-low reset
//   req_valid_i     per-requester write-back valid
//   req_ready_o     per-requester grant, combinational from req_valid_i and the round-robin pointer
//   req_addr_i      per-requester destination register, slice i belongs to requester i
//   req_data_i      per-requester write data, slice i belongs to requester i
//   wr_en_o         registered register file write enable, never set for x0
//   wr_addr_o       registered register file write address
//   wr_data_o       registered register file write data
//   iss_valid_i     issue stage allocates destination iss_rd_i
//   iss_rd_i        destination register being issued
//   iss_ready_o     iss_rd_i has no pending write, so the allocation is taken
//   q_rs1_i/q_rs2_i source registers queried by issue
//   q_rs1_busy_o/q_rs2_busy_o  queried register has a pending write
module regfile_wb_ctrl #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NREQ   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ*WIDTH-1:0]    req_data_i,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic [WIDTH-1:0]         wr_data_o,
    input  logic                     iss_valid_i,
    input  logic [ADDR_W-1:0]        iss_rd_i,
    output logic                     iss_ready_o,
    input  logic [ADDR_W-1:0]        q_rs1_i,
    input  logic [ADDR_W-1:0]        q_rs2_i,
    output logic                     q_rs1_busy_o,
    output logic                     q_rs2_busy_o
);
    localparam int NREG = 2 ** ADDR_W;
    localparam int PW   = $clog2(NREQ);
    logic [PW-1:0]     ptr_q, ptr_d, gnt_idx;
    logic              found;
    int                idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [WIDTH-1:0]  gnt_data;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              iss_take;
    // Walk requesters starting at the pointer; the first valid one wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid_i[idx]) begin
                found   = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end
    always_comb begin
        req_ready_o          = '0;
        req_ready_o[gnt_idx] = found;
    end
    assign gnt_addr = req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign gnt_data = req_data_i[int'(gnt_idx)*WIDTH +: WIDTH];
    // Every accepted request, including x0, advances the pointer; x0 just never raises wr_en.
    assign ptr_d     = found ? ((gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
    assign wr_en_d   = found && (gnt_addr != '0);
    assign wr_addr_d = found ? gnt_addr : wr_addr_q;
    assign wr_data_d = found ? gnt_data : wr_data_q;
    assign iss_ready_o = ~pending_q[iss_rd_i];
    assign iss_take    = iss_valid_i && iss_ready_o && (iss_rd_i != '0);
    // Clear at the commit edge first so a same-edge issue of that register re-arms it.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q) pending_d[wr_addr_q] = 1'b0;
        if (iss_take) pending_d[iss_rd_i] = 1'b1;
        pending_d[0] = 1'b0;
    end
    assign q_rs1_busy_o = pending_q[q_rs1_i];
    assign q_rs2_busy_o = pending_q[q_rs2_i];
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed table-driven bench for regfile_wb_ctrl with NREQ=2
module tb_regfile_wb_ctrl;
    localparam logic [31:0] A = 32'h1111_0003, B = 32'h2222_0004, C = 32'h5555_5555;
    localparam logic [31:0] D = 32'h7777_0007, E = 32'hEEEE_0007, F = 32'h9999_0009;
    localparam logic [31:0] G = 32'hAAAA_000A, X = 32'hDEAD_BEEF;
    typedef struct packed {
        logic        rst_n;
        logic [1:0]  vld;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        iv;
        logic [4:0]  ird, r1, r2;
        logic [1:0]  e_rdy;
        logic        e_irdy, e_b1, e_b2, e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        wr_en, iss_valid, iss_ready, b1, b2;
    logic [4:0]  wr_addr, iss_rd, rs1, rs2;
    logic [31:0] wr_data;
    int          checks = 0, passed = 0;
    vec_t        tv [22];
    always #5 clk = ~clk;
    regfile_wb_ctrl #(.WIDTH(32), .ADDR_W(5), .NREQ(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_ready_o(iss_ready),
        .q_rs1_i(rs1), .q_rs2_i(rs2), .q_rs1_busy_o(b1), .q_rs2_busy_o(b2)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask
    initial begin
        tv[0]  = '{1, 2'b11, 3, 4, A, B, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 2'b11, 3, 4, A, B, 0, 0, 0, 0, 2'b10, 1, 0, 0, 1, 3, A};
        tv[2]  = '{1, 2'b11, 3, 4, A, B, 0, 0, 0, 0, 2'b01, 1, 0, 0, 1, 4, B};
        tv[3]  = '{1, 2'b11, 3, 4, A, B, 0, 0, 0, 0, 2'b10, 1, 0, 0, 1, 3, A};
        tv[4]  = '{1, 2'b00, 3, 4, A, B, 1, 5, 5, 3, 2'b00, 1, 0, 0, 1, 4, B};
        tv[5]  = '{1, 2'b00, 3, 4, A, B, 1, 5, 5, 3, 2'b00, 0, 1, 0, 0, 4, B};
        tv[6]  = '{1, 2'b01, 5, 4, C, B, 0, 5, 5, 3, 2'b01, 0, 1, 0, 0, 4, B};
        tv[7]  = '{1, 2'b00, 5, 4, C, B, 0, 5, 5, 3, 2'b00, 0, 1, 0, 1, 5, C};
        tv[8]  = '{1, 2'b00, 5, 4, C, B, 0, 5, 5, 3, 2'b00, 1, 0, 0, 0, 5, C};
        tv[9]  = '{1, 2'b10, 5, 0, C, X, 0, 5, 5, 3, 2'b10, 1, 0, 0, 0, 5, C};
        tv[10] = '{1, 2'b00, 5, 0, C, X, 0, 5, 5, 3, 2'b00, 1, 0, 0, 0, 0, X};
        tv[11] = '{1, 2'b00, 5, 0, C, X, 1, 7, 7, 3, 2'b00, 1, 0, 0, 0, 0, X};
        tv[12] = '{1, 2'b01, 7, 0, D, X, 0, 7, 7, 3, 2'b01, 0, 1, 0, 0, 0, X};
        tv[13] = '{1, 2'b00, 7, 0, D, X, 1, 7, 7, 3, 2'b00, 0, 1, 0, 1, 7, D};
        tv[14] = '{1, 2'b00, 7, 0, D, X, 0, 7, 7, 3, 2'b00, 1, 0, 0, 0, 7, D};
        tv[15] = '{1, 2'b10, 7, 7, D, E, 0, 7, 7, 3, 2'b10, 1, 0, 0, 0, 7, D};
        tv[16] = '{1, 2'b00, 7, 7, D, E, 1, 7, 7, 3, 2'b00, 1, 0, 0, 1, 7, E};
        tv[17] = '{1, 2'b00, 7, 7, D, E, 0, 7, 7, 5, 2'b00, 0, 1, 0, 0, 7, E};
        tv[18] = '{1, 2'b11, 9, 10, F, G, 0, 7, 7, 5, 2'b01, 0, 1, 0, 0, 7, E};
        tv[19] = '{0, 2'b11, 9, 10, F, G, 0, 7, 7, 5, 2'b10, 0, 1, 0, 1, 9, F};
        tv[20] = '{1, 2'b11, 9, 10, F, G, 0, 7, 7, 5, 2'b01, 1, 0, 0, 0, 0, 0};
        tv[21] = '{1, 2'b00, 9, 10, F, G, 0, 0, 9, 5, 2'b00, 1, 0, 0, 1, 9, F};
        rst_n = 1'b0; req_valid = 2'b11; req_addr = {5'd4, 5'd3}; req_data = {B, A};
        iss_valid = 1'b1; iss_rd = 5'd5; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            rst_n = tv[i].rst_n; req_valid = tv[i].vld;
            req_addr = {tv[i].a1, tv[i].a0}; req_data = {tv[i].d1, tv[i].d0};
            iss_valid = tv[i].iv; iss_rd = tv[i].ird; rs1 = tv[i].r1; rs2 = tv[i].r2;
            #2;
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tv[i].e_rdy));
            chk($sformatf("v%0d iss_ready", i), 32'(iss_ready), 32'(tv[i].e_irdy));
            chk($sformatf("v%0d rs1_busy", i), 32'(b1), 32'(tv[i].e_b1));
            chk($sformatf("v%0d rs2_busy", i), 32'(b2), 32'(tv[i].e_b2));
            chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(tv[i].e_wen));
            chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(tv[i].e_waddr));
            chk($sformatf("v%0d wr_data", i), wr_data, tv[i].e_wdata);
        end
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            req_valid = 2'b00; iss_valid = 1'b1; iss_rd = 5'(r);
            #2;
            chk($sformatf("fill iss_ready rd%0d", r), 32'(iss_ready), 32'd1);
        end
        @(negedge clk);
        iss_rd = 5'd0;
        #2;
        chk("x0 iss_ready", 32'(iss_ready), 32'd1);
        @(negedge clk);
        iss_valid = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rs2 = 5'(r);
            #1;
            chk($sformatf("scan rs2_busy r%0d", r), 32'(b2), (r != 0) ? 32'd1 : 32'd0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the integer register file. It arbitrates up to NREQ write-back requesters (ALU, LSU, mul/div) onto the register file's single write port using round-robin arbitration with a valid/ready handshake. It also keeps a per-register pending scoreboard so the issue stage can detect RAW and WAW hazards. It sits between the execute units and the register file's write port (wr_en/wr_addr/wr_data).

## Interface
- WIDTH, 32: data width of a register.
- ADDR_W, 5: register address width (2**ADDR_W registers).
- NREQ, 2: number of write-back requesters, 2..4.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  requester i holds a write-back.
- req_ready  out  NREQ  requester i is granted this cycle.
- req_addr  in  NREQ*ADDR_W  destination register; slice i belongs to requester i.
- req_data  in  NREQ*WIDTH  write data; slice i belongs to requester i.
- wr_en  out  1  register file write enable (registered).
- wr_addr  out  ADDR_W  register file write address (registered).
- wr_data  out  WIDTH  register file write data (registered).
- iss_valid  in  1  issue stage allocates destination iss_rd.
- iss_rd  in  ADDR_W  destination register being issued.
- iss_ready  out  1  iss_rd is free; the allocation will be taken.
- q_rs1, q_rs2  in  ADDR_W  source registers queried by issue.
- q_rs1_busy, q_rs2_busy  out  1  the queried register has a pending write.

## Operation
- Arbiter state: round-robin pointer ptr, range 0..NREQ-1.
- Grant rule: search from ptr upward, wrapping. The first i with req_valid[i]=1 gets req_ready[i]=1; every other ready bit is 0. req_ready is combinational from req_valid and ptr.
- At most one grant per cycle.
- Acceptance means req_valid[i] & req_ready[i] at a rising edge. On acceptance:
  - ptr <= (i+1) mod NREQ.
  - wr_addr <= req_addr[i]; wr_data <= req_data[i].
  - wr_en <= (req_addr[i] != 0).
- x0 writes are accepted and consumed but never reach the register file.
- No acceptance: wr_en <= 0. wr_addr, wr_data and ptr hold their values.
- Requesters keep valid, addr and data stable until they see ready. There is no back-pressure from the register file.
- Scoreboard: pending[2**ADDR_W-1:0].
  - pending[0] is always 0.
  - Set: iss_valid & iss_ready & (iss_rd != 0) sets pending[iss_rd] at the edge.
  - Clear: wr_en=1 at an edge clears pending[wr_addr]. This is the edge at which the register file commits the data.
  - Set and clear of the same register at the same edge: set wins, because a new producer has been issued.
- iss_ready = ~pending[iss_rd]. A second writer to a register that is still pending stalls (WAW). iss_rd=0 always has iss_ready=1.
- q_rsN_busy = pending[q_rsN], combinational.
  - The cycle after the clearing edge, busy=0 and the asynchronous register-file read returns the new value.
  - No forwarding is provided.
- A write-back to a register with no pending bit set is legal and performed. The scoreboard is unchanged.

## Timing
- Reset (rst=0 at an edge): ptr=0, wr_en=0, wr_addr=0, wr_data=0, all pending=0. Inputs are ignored that cycle.
- Reset mid-operation drops any in-flight write-back. wr_en reads 0 the cycle after the reset edge.
- req_ready is valid in the same cycle as req_valid, with zero latency.
- Acceptance at edge N gives wr_en/addr/data valid during cycle N+1. The register file holds the data after edge N+1.
- Issue at edge N gives busy=1 from cycle N+1. Commit at edge M gives busy=0 from cycle M+1.
- Throughput: one write-back per cycle sustained. Under continuous contention each requester is granted at least once every NREQ cycles.

## Test plan
- Reset: hold rst=0 with all req_valid=1. Response: req_ready=0 is not required, but after reset wr_en=0, all busy=0, and the first grant goes to requester 0.
- Fairness, NREQ=2: both valid for 4 cycles with addrs 3 and 4. Response: grants 0,1,0,1; wr_addr sequence 3,4,3,4, each one cycle after its grant.
- x0 suppression: requester 1 writes addr 0, data 0xDEADBEEF. Response: req_ready[1]=1 and wr_en stays 0 the next cycle.
- Scoreboard: issue rd=5, then one cycle later write-back to 5. Response: q_rs1_busy(5)=1 until the cycle after wr_en=1 with wr_addr=5; iss_ready for rd=5 is 0 while pending.
- Set/clear collision: wr_en=1 with wr_addr=7 in the same cycle as iss_valid with iss_rd=7 while pending[7]=1. Response: iss_ready=0, so no set occurs, and pending[7]=0 next cycle. Repeat with pending[7]=0 and an unsolicited write to 7 plus issue of 7: pending[7]=1 next cycle.
- Reset mid-stream: rst=0 in the cycle after an acceptance. Response: wr_en=0 next cycle, pending cleared, ptr=0.
